snitch_pma_region_cfg: RTL and testbench

- Runtime-programmable physical memory attribute (PMA) table for the Snitch cluster. It replaces compile-time cached/execute region constants with NrRules writable base/mask/attribute rules.
- Exposes a register-style configuration port for the cluster peripheral path.
- Has a one-stage, back-pressurable lookup pipeline that the instruction cache and LSU query for cached and executable attributes.
- Adds a sticky lock bit and a priority-encoded hit index, neither of which the static configuration has.

---
 rtl/snitch_pma_region_cfg.sv | 213 +++++++++++++++++++++
 tb/tb_snitch_pma_region_cfg.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_pma_region_cfg.sv
// snitch_pma_region_cfg
//
// Runtime-programmable physical memory attribute table for the Snitch
// cluster. NrRules base/mask/attr rules are written through a simple
// register-style port. The instruction cache and LSU query the table
// through a one-stage lookup pipeline that can be stalled from the
// output side.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cfg_req_i/cfg_we_i    configuration request, 1 = write
//   cfg_idx_i/cfg_wdata_i word index and write data
//   cfg_gnt_o             grant (always equal to the request)
//   cfg_rvalid_o          one-cycle response strobe, one cycle after grant
//   cfg_rdata_o/cfg_err_o registered read data and error flag
//   lk_valid_i/lk_ready_o lookup request handshake
//   lk_addr_i             address to classify
//   lk_valid_o/lk_ready_i lookup result handshake
//   lk_hit_o/lk_idx_o     match flag and index of the winning rule
//   lk_cached_o/lk_exec_o attributes of the winning rule (or defaults)
//   locked_o              sticky table lock status
//
// Register map: rule r uses words 4r (base), 4r+1 (mask), 4r+2 (attr:
// bit0 cached, bit1 exec, bit2 enable), 4r+3 (reserved, reads 0).
// Word 4*NrRules is CTRL: bit0 lock, bit1 default_exec.
module snitch_pma_region_cfg #(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          NrRules   = 4,
   parameter logic [AddrWidth-1:0] ResetBase = 32'h1e000000,
   parameter logic [AddrWidth-1:0] ResetMask = 32'h00800000,
   parameter int unsigned          IdxWidth  = $clog2(NrRules*4+1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [IdxWidth-1:0]  cfg_idx_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   output logic                 cfg_gnt_o,
   output logic                 cfg_rvalid_o,
   output logic [AddrWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 lk_valid_i,
   output logic                 lk_ready_o,
   input  logic [AddrWidth-1:0] lk_addr_i,
   output logic                 lk_valid_o,
   input  logic                 lk_ready_i,
   output logic                 lk_hit_o,
   output logic [((NrRules > 1) ? $clog2(NrRules) : 1)-1:0] lk_idx_o,
   output logic                 lk_cached_o,
   output logic                 lk_exec_o,
   output logic                 locked_o
);

   localparam int unsigned LkIdxW   = (NrRules > 1) ? $clog2(NrRules) : 1;
   localparam int unsigned RuleSelW = IdxWidth - 2;
   localparam logic [IdxWidth-1:0] CtrlIdx = IdxWidth'(NrRules * 4);

   logic [AddrWidth-1:0] base_q [NrRules];
   logic [AddrWidth-1:0] mask_q [NrRules];
   logic [2:0]           attr_q [NrRules];
   logic                 lock_q;
   logic                 dexec_q;

   logic [1:0]           word_sel;
   logic [RuleSelW-1:0]  rule_sel;
   logic                 is_oob;
   logic                 is_ctrl;
   logic                 cfg_err;
   logic                 cfg_wr;
   logic [AddrWidth-1:0] rd_data;

   logic                 rvalid_q;
   logic                 err_q;
   logic [AddrWidth-1:0] rdata_q;

   logic                 hit_d;
   logic [LkIdxW-1:0]    idx_d;
   logic                 cached_d;
   logic                 exec_d;
   logic                 lk_accept;

   logic                 lk_valid_q;
   logic                 lk_hit_q;
   logic [LkIdxW-1:0]    lk_idx_q;
   logic                 lk_cached_q;
   logic                 lk_exec_q;

   // Decode the configuration word, flag errors and build read data.
   // Once locked, every in-range write is refused; reads stay open.
   always_comb begin
      word_sel = cfg_idx_i[1:0];
      rule_sel = cfg_idx_i[IdxWidth-1:2];
      is_oob   = cfg_idx_i > CtrlIdx;
      is_ctrl  = cfg_idx_i == CtrlIdx;
      cfg_err  = cfg_req_i && (is_oob || (cfg_we_i && lock_q));
      cfg_wr   = cfg_req_i && cfg_we_i && !cfg_err;
      rd_data  = '0;
      if (is_ctrl) begin
         rd_data = AddrWidth'({dexec_q, lock_q});
      end else if (!is_oob) begin
         for (int r = 0; r < int'(NrRules); r++) begin
            if (rule_sel == RuleSelW'(r)) begin
               case (word_sel)
                  2'd0:    rd_data = base_q[r];
                  2'd1:    rd_data = mask_q[r];
                  2'd2:    rd_data = AddrWidth'(attr_q[r]);
                  default: rd_data = '0;
               endcase
            end
         end
      end
   end

   // Table storage. Rule 0 resets to the boot region so fetches work
   // before software has programmed anything. Reserved words drop writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < int'(NrRules); r++) begin
            base_q[r] <= '0;
            mask_q[r] <= '0;
            attr_q[r] <= '0;
         end
         base_q[0] <= ResetBase;
         mask_q[0] <= ResetMask;
         attr_q[0] <= 3'b111;
         lock_q    <= 1'b0;
         dexec_q   <= 1'b0;
      end else if (cfg_wr) begin
         if (is_ctrl) begin
            lock_q  <= cfg_wdata_i[0];
            dexec_q <= cfg_wdata_i[1];
         end else begin
            for (int r = 0; r < int'(NrRules); r++) begin
               if (rule_sel == RuleSelW'(r)) begin
                  case (word_sel)
                     2'd0:    base_q[r] <= cfg_wdata_i;
                     2'd1:    mask_q[r] <= cfg_wdata_i;
                     2'd2:    attr_q[r] <= cfg_wdata_i[2:0];
                     default: ;
                  endcase
               end
            end
         end
      end
   end

   // Configuration response, one cycle after the grant. Writes and
   // errored accesses return zero data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= cfg_req_i;
         err_q    <= cfg_err;
         rdata_q  <= (cfg_req_i && !cfg_we_i && !cfg_err) ? rd_data : '0;
      end
   end

   // Priority match: scan from the top so the lowest matching index is
   // the last assignment and therefore wins.
   always_comb begin
      hit_d    = 1'b0;
      idx_d    = '0;
      cached_d = 1'b0;
      exec_d   = dexec_q;
      for (int r = int'(NrRules) - 1; r >= 0; r--) begin
         if (attr_q[r][2] && (((lk_addr_i ^ base_q[r]) & mask_q[r]) == '0)) begin
            hit_d    = 1'b1;
            idx_d    = LkIdxW'(r);
            cached_d = attr_q[r][0];
            exec_d   = attr_q[r][1];
         end
      end
   end

   assign lk_ready_o = !lk_valid_q || lk_ready_i;
   assign lk_accept  = lk_valid_i && lk_ready_o;

   // Result register. It only loads on accept, so a stalled result is
   // frozen even if the table is rewritten underneath it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lk_valid_q  <= 1'b0;
         lk_hit_q    <= 1'b0;
         lk_idx_q    <= '0;
         lk_cached_q <= 1'b0;
         lk_exec_q   <= 1'b0;
      end else if (lk_accept) begin
         lk_valid_q  <= 1'b1;
         lk_hit_q    <= hit_d;
         lk_idx_q    <= idx_d;
         lk_cached_q <= cached_d;
         lk_exec_q   <= exec_d;
      end else if (lk_ready_i) begin
         lk_valid_q  <= 1'b0;
      end
   end

   assign cfg_gnt_o    = cfg_req_i;
   assign cfg_rvalid_o = rvalid_q;
   assign cfg_rdata_o  = rdata_q;
   assign cfg_err_o    = err_q;
   assign lk_valid_o   = lk_valid_q;
   assign lk_hit_o     = lk_hit_q;
   assign lk_idx_o     = lk_idx_q;
   assign lk_cached_o  = lk_cached_q;
   assign lk_exec_o    = lk_exec_q;
   assign locked_o     = lock_q;

endmodule

// File: tb/tb_snitch_pma_region_cfg.sv
// tb_snitch_pma_region_cfg
//
// Directed bench for snitch_pma_region_cfg with the default parameters
// (32-bit addresses, 4 rules). Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, so each sampled value reflects
// the edge just passed.
module tb_snitch_pma_region_cfg;

   logic        clk_i;
   logic        rst_i;
   logic        cfg_req_i;
   logic        cfg_we_i;
   logic [4:0]  cfg_idx_i;
   logic [31:0] cfg_wdata_i;
   logic        cfg_gnt_o;
   logic        cfg_rvalid_o;
   logic [31:0] cfg_rdata_o;
   logic        cfg_err_o;
   logic        lk_valid_i;
   logic        lk_ready_o;
   logic [31:0] lk_addr_i;
   logic        lk_valid_o;
   logic        lk_ready_i;
   logic        lk_hit_o;
   logic [1:0]  lk_idx_o;
   logic        lk_cached_o;
   logic        lk_exec_o;
   logic        locked_o;

   int checks = 0;
   int errors = 0;

   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_data;

   snitch_pma_region_cfg dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cfg_req_i    (cfg_req_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_idx_i    (cfg_idx_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_gnt_o    (cfg_gnt_o),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .cfg_err_o    (cfg_err_o),
      .lk_valid_i   (lk_valid_i),
      .lk_ready_o   (lk_ready_o),
      .lk_addr_i    (lk_addr_i),
      .lk_valid_o   (lk_valid_o),
      .lk_ready_i   (lk_ready_i),
      .lk_hit_o     (lk_hit_o),
      .lk_idx_o     (lk_idx_o),
      .lk_cached_o  (lk_cached_o),
      .lk_exec_o    (lk_exec_o),
      .locked_o     (locked_o)
   );

   // 100 MHz clock, rising edges at 5, 15, 25 ns ...
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Single comparison point: count, and report any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One configuration access; returns the response seen one cycle later.
   task automatic applyStimulus(input logic we, input logic [4:0] idx, input logic [31:0] wdata,
                                output logic rv, output logic err, output logic [31:0] rdata);
      cfg_req_i   = 1'b1;
      cfg_we_i    = we;
      cfg_idx_i   = idx;
      cfg_wdata_i = wdata;
      #1;
      checks++;
      if (cfg_gnt_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL gnt: got %0b, expected 1", cfg_gnt_o);
      end
      @(posedge clk_i);
      #1;
      cfg_req_i   = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_wdata_i = '0;
      rv    = cfg_rvalid_o;
      err   = cfg_err_o;
      rdata = cfg_rdata_o;
   endtask

   // Present one lookup for one cycle; the result is visible on return.
   task automatic applyLookup(input logic [31:0] addr);
      lk_valid_i = 1'b1;
      lk_addr_i  = addr;
      @(posedge clk_i);
      #1;
      lk_valid_i = 1'b0;
   endtask

   task automatic checkLookup(input string tag, input logic hit, input logic [1:0] idx,
                              input logic cached, input logic exec);
      checkOutput({tag, ".valid"},  {31'd0, lk_valid_o},  32'd1);
      checkOutput({tag, ".hit"},    {31'd0, lk_hit_o},    {31'd0, hit});
      checkOutput({tag, ".idx"},    {30'd0, lk_idx_o},    {30'd0, idx});
      checkOutput({tag, ".cached"}, {31'd0, lk_cached_o}, {31'd0, cached});
      checkOutput({tag, ".exec"},   {31'd0, lk_exec_o},   {31'd0, exec});
   endtask

   task automatic pulseReset();
      rst_i = 1'b1;
      #2;
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i       = 1'b1;
      cfg_req_i   = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_idx_i   = '0;
      cfg_wdata_i = '0;
      lk_valid_i  = 1'b0;
      lk_addr_i   = '0;
      lk_ready_i  = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Reset state
      checkOutput("rst.lk_valid", {31'd0, lk_valid_o},   32'd0);
      checkOutput("rst.lk_ready", {31'd0, lk_ready_o},   32'd1);
      checkOutput("rst.rvalid",   {31'd0, cfg_rvalid_o}, 32'd0);
      checkOutput("rst.rdata",    cfg_rdata_o,           32'd0);
      checkOutput("rst.locked",   {31'd0, locked_o},     32'd0);
      checkOutput("rst.exec",     {31'd0, lk_exec_o},    32'd0);

      // 1: reset rule 0 covers the boot region
      applyLookup(32'h1e000100);
      checkLookup("t1.hit", 1'b1, 2'd0, 1'b1, 1'b1);
      applyLookup(32'h1e800000);
      checkLookup("t1.miss", 1'b0, 2'd0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      checkOutput("t1.valid_drop", {31'd0, lk_valid_o}, 32'd0);

      // 2: program rule 1
      applyStimulus(1'b1, 5'd4, 32'h80000000, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.wr_rvalid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("t2.wr_rdata",  rsp_data,           32'd0);
      checkOutput("t2.wr_err",    {31'd0, rsp_err},   32'd0);
      applyStimulus(1'b1, 5'd5, 32'hF0000000, rsp_valid, rsp_err, rsp_data);
      applyStimulus(1'b1, 5'd6, 32'hFFFFFFFD, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.rvalid_drop", {31'd0, cfg_rvalid_o}, 32'd1);
      applyLookup(32'h8abc0000);
      checkOutput("t2.rvalid_idle", {31'd0, cfg_rvalid_o}, 32'd0);
      checkLookup("t2.rule1", 1'b1, 2'd1, 1'b1, 1'b0);
      applyStimulus(1'b0, 5'd6, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.rd_attr", rsp_data,         32'd5);
      checkOutput("t2.rd_err",  {31'd0, rsp_err}, 32'd0);
      applyStimulus(1'b0, 5'd5, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.rd_mask", rsp_data, 32'hF0000000);
      applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.wr_rsvd_err", {31'd0, rsp_err}, 32'd0);
      applyStimulus(1'b0, 5'd7, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t2.rd_rsvd", rsp_data, 32'd0);

      // 3: rule 2 overlaps rule 0 with different attributes
      applyStimulus(1'b1, 5'd8,  32'h1e000000, rsp_valid, rsp_err, rsp_data);
      applyStimulus(1'b1, 5'd9,  32'hFFFFFFFF, rsp_valid, rsp_err, rsp_data);
      applyStimulus(1'b1, 5'd10, 32'h00000006, rsp_valid, rsp_err, rsp_data);
      applyLookup(32'h1e000000);
      checkLookup("t3.prio", 1'b1, 2'd0, 1'b1, 1'b1);
      applyStimulus(1'b1, 5'd2, 32'h00000003, rsp_valid, rsp_err, rsp_data);
      applyLookup(32'h1e000000);
      checkLookup("t3.rule2", 1'b1, 2'd2, 1'b0, 1'b1);

      // 4: lock with default_exec
      applyStimulus(1'b1, 5'd16, 32'h00000003, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.lock_wr_err", {31'd0, rsp_err},  32'd0);
      checkOutput("t4.locked",      {31'd0, locked_o}, 32'd1);
      applyStimulus(1'b1, 5'd0, 32'h12345678, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.locked_wr_err",   {31'd0, rsp_err}, 32'd1);
      checkOutput("t4.locked_wr_rdata", rsp_data,         32'd0);
      applyStimulus(1'b0, 5'd0, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.base0_kept", rsp_data,         32'h1e000000);
      checkOutput("t4.rd_err",     {31'd0, rsp_err}, 32'd0);
      applyStimulus(1'b1, 5'd16, 32'h00000000, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.unlock_err", {31'd0, rsp_err},  32'd1);
      checkOutput("t4.still_lock", {31'd0, locked_o}, 32'd1);
      applyStimulus(1'b0, 5'd16, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.rd_ctrl", rsp_data, 32'd3);
      applyLookup(32'h00000000);
      checkLookup("t4.miss_dexec", 1'b0, 2'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 5'd17, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t4.oob_err",   {31'd0, rsp_err}, 32'd1);
      checkOutput("t4.oob_rdata", rsp_data,         32'd0);

      // Reset clears the lock so the stall test can rewrite rule 0
      pulseReset();
      checkOutput("t5.unlocked", {31'd0, locked_o}, 32'd0);

      // 5: stall with a pending result while rule 0's attr is rewritten
      lk_ready_i = 1'b0;
      applyLookup(32'h1e000100);
      checkLookup("t5.first", 1'b1, 2'd0, 1'b1, 1'b1);
      for (int c = 0; c < 5; c++) begin
         if (c == 0) begin
            lk_valid_i = 1'b1;
            lk_addr_i  = 32'h00000000;
            applyStimulus(1'b1, 5'd2, 32'h00000004, rsp_valid, rsp_err, rsp_data);
            lk_valid_i = 1'b0;
         end else begin
            @(posedge clk_i);
            #1;
         end
         checkLookup($sformatf("t5.hold%0d", c), 1'b1, 2'd0, 1'b1, 1'b1);
         checkOutput($sformatf("t5.ready%0d", c), {31'd0, lk_ready_o}, 32'd0);
      end
      lk_ready_i = 1'b1;
      applyLookup(32'h1e000100);
      checkLookup("t5.new_attr", 1'b1, 2'd0, 1'b0, 1'b0);

      // 6: eight back-to-back lookups, alternating hit and miss
      for (int i = 0; i < 8; i++) begin
         lk_valid_i = 1'b1;
         lk_addr_i  = (i % 2 == 0) ? (32'h1e000000 + 32'(i)) : 32'h1e800000;
         @(posedge clk_i);
         #1;
         checkLookup($sformatf("t6.s%0d", i), (i % 2 == 0), 2'd0, 1'b0, 1'b0);
      end
      // Keep streaming with a read in flight, then reset between edges
      cfg_req_i = 1'b1;
      cfg_we_i  = 1'b0;
      cfg_idx_i = 5'd0;
      @(posedge clk_i);
      #1;
      cfg_req_i = 1'b0;
      checkOutput("t6.pre_rvalid", {31'd0, cfg_rvalid_o}, 32'd1);
      checkOutput("t6.pre_valid",  {31'd0, lk_valid_o},   32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      checkOutput("t6.rst_valid",  {31'd0, lk_valid_o},   32'd0);
      checkOutput("t6.rst_rvalid", {31'd0, cfg_rvalid_o}, 32'd0);
      lk_valid_i = 1'b0;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      applyStimulus(1'b0, 5'd2, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t6.attr0_rst", rsp_data, 32'd7);
      applyStimulus(1'b0, 5'd4, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t6.base1_rst", rsp_data, 32'd0);
      applyStimulus(1'b0, 5'd10, 32'd0, rsp_valid, rsp_err, rsp_data);
      checkOutput("t6.attr2_rst", rsp_data, 32'd0);
      applyLookup(32'h1e000100);
      checkLookup("t6.after_rst", 1'b1, 2'd0, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
